// File: rtl/cnt_ctl.sv
`default_nettype none
// ============================================================================
// Module   : cnt_ctl
// Brief    : Prescaled period counter, one-shot or periodic, sticky irq/ovr.
// Revision : 1.0
// ============================================================================
module cnt_ctl #(
    parameter int width  = 32,
    parameter int pwidth = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [width-1:0]  top_in,
    input  logic [pwidth-1:0] pre_in,
    input  logic              start,
    input  logic              stop,
    input  logic              periodic,
    input  logic              ack,
    output logic [width-1:0]  cnt,
    output logic              running,
    output logic              irq,
    output logic              ovr
);

    localparam logic [0:0]        c_IDLE    = 1'b0;
    localparam logic [0:0]        c_RUN     = 1'b1;
    localparam logic [width-1:0]  c_CNT_ONE = width'(1);
    localparam logic [pwidth-1:0] c_PRE_ONE = pwidth'(1);

    logic [0:0]        r_state;
    logic [width-1:0]  r_top;
    logic [width-1:0]  r_cnt;
    logic [pwidth-1:0] r_pre;
    logic [pwidth-1:0] r_pcnt;
    logic              r_mode;
    logic              r_irq;
    logic              r_ovr;

    logic w_run;
    logic w_start_ok;
    logic w_tick;
    logic w_last;
    logic w_expire;

    assign w_run      = (r_state == c_RUN);
    assign w_start_ok = start && (r_top != '0);
    assign w_tick     = w_run && (r_pcnt == r_pre);
    assign w_last     = (r_cnt == (r_top - c_CNT_ONE));
    // A stop or restart in the same cycle pre-empts the expiry.
    assign w_expire   = w_tick && w_last && !stop && !w_start_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_pcnt  <= '0;
            r_mode  <= 1'b0;
        end else if (stop) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_pcnt  <= '0;
        end else if (w_start_ok) begin
            r_state <= c_RUN;
            r_cnt   <= '0;
            r_pcnt  <= '0;
            r_mode  <= periodic;
        end else if (w_run) begin
            if (w_tick) begin
                r_pcnt <= '0;
                if (w_last) begin
                    r_cnt <= '0;
                    if (!r_mode) begin
                        r_state <= c_IDLE;
                    end
                end else begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                end
            end else begin
                r_pcnt <= r_pcnt + c_PRE_ONE;
            end
        end
    end

    // Configuration only changes while idle so an active period is never disturbed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_top <= '0;
            r_pre <= '0;
        end else if (load && !w_run) begin
            r_top <= top_in;
            r_pre <= pre_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq <= 1'b0;
            r_ovr <= 1'b0;
        end else if (w_expire) begin
            r_irq <= 1'b1;
            r_ovr <= ack ? 1'b0 : (r_ovr | r_irq);
        end else if (ack) begin
            r_irq <= 1'b0;
            r_ovr <= 1'b0;
        end
    end

    assign cnt     = r_cnt;
    assign running = w_run;
    assign irq     = r_irq;
    assign ovr     = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_cnt_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnt_ctl
// Brief    : Directed scoreboard bench for cnt_ctl.
// Revision : 1.0
// ============================================================================
module tb_cnt_ctl;

    logic        clk;
    logic        rst;
    logic        load;
    logic [31:0] top_in;
    logic [7:0]  pre_in;
    logic        start;
    logic        stop;
    logic        periodic;
    logic        ack;
    logic [31:0] cnt;
    logic        running;
    logic        irq;
    logic        ovr;

    cnt_ctl #(.width(32), .pwidth(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .top_in   (top_in),
        .pre_in   (pre_in),
        .start    (start),
        .stop     (stop),
        .periodic (periodic),
        .ack      (ack),
        .cnt      (cnt),
        .running  (running),
        .irq      (irq),
        .ovr      (ovr)
    );

    typedef struct packed {
        logic [31:0] cnt;
        logic        running;
        logic        irq;
        logic        ovr;
    } obs_t;

    obs_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference view of the block, advanced once per driven cycle.
    longint m_top, m_cnt;
    int     m_pre, m_pcnt;
    bit     m_run, m_mode, m_irq, m_ovr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit rs, input bit ld, input bit st, input bit sp,
                       input bit per, input bit ak, input logic [31:0] t, input logic [7:0] p);
        bit   was_run, go, ev;
        obs_t got, exp;
        rst = rs; load = ld; start = st; stop = sp; periodic = per; ack = ak;
        top_in = t; pre_in = p;
        was_run = m_run;
        ev = 1'b0;
        if (rs) begin
            m_run = 0; m_cnt = 0; m_pcnt = 0; m_top = 0; m_pre = 0;
            m_mode = 0; m_irq = 0; m_ovr = 0;
        end else begin
            go = st && (m_top != 0);
            if (sp) begin
                m_run = 0; m_cnt = 0; m_pcnt = 0;
            end else if (go) begin
                m_run = 1; m_cnt = 0; m_pcnt = 0; m_mode = per;
            end else if (m_run) begin
                if (m_pcnt == m_pre) begin
                    m_pcnt = 0;
                    if (m_cnt + 1 == m_top) begin
                        m_cnt = 0;
                        ev = 1'b1;
                        if (!m_mode) m_run = 0;
                    end else begin
                        m_cnt = m_cnt + 1;
                    end
                end else begin
                    m_pcnt = m_pcnt + 1;
                end
            end
            if (ld && !was_run) begin
                m_top = longint'(t);
                m_pre = int'(p);
            end
            if (ev) begin
                m_ovr = ak ? 1'b0 : (m_ovr | m_irq);
                m_irq = 1'b1;
            end else if (ak) begin
                m_irq = 1'b0;
                m_ovr = 1'b0;
            end
        end
        sb.push_back('{cnt: 32'(m_cnt), running: m_run, irq: m_irq, ovr: m_ovr});
        @(posedge clk);
        #1;
        got = '{cnt: cnt, running: running, irq: irq, ovr: ovr};
        exp = sb.pop_front();
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL cycle_model: observed cnt=%0d run=%b irq=%b ovr=%b expected cnt=%0d run=%b irq=%b ovr=%b",
                   got.cnt, got.running, got.irq, got.ovr, exp.cnt, exp.running, exp.irq, exp.ovr);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 32'd0, 8'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_top = 0; m_cnt = 0; m_pre = 0; m_pcnt = 0;
        m_run = 0; m_mode = 0; m_irq = 0; m_ovr = 0;

        // Reset
        cyc(1, 0, 0, 0, 0, 0, 32'd0, 8'd0);
        chk("rst_cnt", cnt, 32'd0);
        chk("rst_running", {31'd0, running}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_ovr", {31'd0, ovr}, 32'd0);

        // Periodic, top=4 pre=0
        cyc(0, 1, 0, 0, 0, 0, 32'd4, 8'd0);
        cyc(0, 0, 1, 0, 1, 0, 32'd0, 8'd0);
        chk("s1_running", {31'd0, running}, 32'd1);
        chk("s1_cnt0", cnt, 32'd0);
        idle(3);
        chk("s1_cnt3", cnt, 32'd3);
        chk("s1_irq_low", {31'd0, irq}, 32'd0);
        idle(1);
        chk("s1_wrap", cnt, 32'd0);
        chk("s1_irq", {31'd0, irq}, 32'd1);
        cyc(0, 0, 0, 0, 0, 1, 32'd0, 8'd0);
        chk("s1_ack", {31'd0, irq}, 32'd0);
        idle(2);
        chk("s1_irq_gap", {31'd0, irq}, 32'd0);
        idle(1);
        chk("s1_irq2", {31'd0, irq}, 32'd1);

        // One-shot, top=3 pre=1
        cyc(0, 0, 0, 1, 0, 0, 32'd0, 8'd0);
        cyc(0, 1, 0, 0, 0, 1, 32'd3, 8'd1);
        cyc(0, 0, 1, 0, 0, 0, 32'd0, 8'd0);
        chk("s2_running", {31'd0, running}, 32'd1);
        idle(1);
        chk("s2_hold", cnt, 32'd0);
        idle(1);
        chk("s2_cnt1", cnt, 32'd1);
        idle(3);
        chk("s2_cnt2", cnt, 32'd2);
        chk("s2_still_run", {31'd0, running}, 32'd1);
        idle(1);
        chk("s2_irq", {31'd0, irq}, 32'd1);
        chk("s2_stopped", {31'd0, running}, 32'd0);
        idle(2);
        chk("s2_cnt_idle", cnt, 32'd0);

        // Overrun, top=2 pre=0
        cyc(0, 1, 0, 0, 0, 1, 32'd2, 8'd0);
        cyc(0, 0, 1, 0, 1, 0, 32'd0, 8'd0);
        idle(2);
        chk("s3_irq", {31'd0, irq}, 32'd1);
        chk("s3_ovr_low", {31'd0, ovr}, 32'd0);
        idle(2);
        chk("s3_ovr", {31'd0, ovr}, 32'd1);
        cyc(0, 0, 0, 0, 0, 1, 32'd0, 8'd0);
        chk("s3_ack_irq", {31'd0, irq}, 32'd0);
        chk("s3_ack_ovr", {31'd0, ovr}, 32'd0);

        // Ack coinciding with expiry
        idle(2);
        cyc(0, 0, 0, 0, 0, 1, 32'd0, 8'd0);
        chk("s4_irq", {31'd0, irq}, 32'd1);
        chk("s4_ovr", {31'd0, ovr}, 32'd0);

        // Start+stop, zero top, load during run
        cyc(0, 0, 1, 1, 1, 0, 32'd0, 8'd0);
        chk("s5_stop_wins", {31'd0, running}, 32'd0);
        chk("s5_irq_kept", {31'd0, irq}, 32'd1);
        cyc(0, 1, 0, 0, 0, 1, 32'd0, 8'd0);
        cyc(0, 0, 1, 0, 1, 0, 32'd0, 8'd0);
        chk("s5_zero_top", {31'd0, running}, 32'd0);
        cyc(0, 1, 0, 0, 0, 0, 32'd3, 8'd0);
        cyc(0, 0, 1, 0, 1, 0, 32'd0, 8'd0);
        cyc(0, 1, 0, 0, 0, 0, 32'd9, 8'd0);
        idle(2);
        chk("s5_period_cnt", cnt, 32'd0);
        chk("s5_period_irq", {31'd0, irq}, 32'd1);

        // Reset mid-run with irq pending
        cyc(1, 0, 0, 0, 0, 0, 32'd0, 8'd0);
        chk("s6_cnt", cnt, 32'd0);
        chk("s6_running", {31'd0, running}, 32'd0);
        chk("s6_irq", {31'd0, irq}, 32'd0);
        chk("s6_ovr", {31'd0, ovr}, 32'd0);
        cyc(0, 0, 1, 0, 1, 0, 32'd0, 8'd0);
        chk("s6_start_ignored", {31'd0, running}, 32'd0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
